pipeline_ctrl: RTL and testbench

Hazard and stall controller for the 5-stage RISC-V pipeline. It sequences the pipeline registers and the PC:
- freezes everything while the data cache services a miss;
- inserts a bubble into ID/EX on a load-use hazard (drives the ID/EX `NoOp` input);
- flushes IF/ID on a branch taken in ID.

It also keeps saturating performance counters and halts with a sticky error if a memory access never completes.

---
 rtl/pipe_ctrl_pkg.sv | 5 +
 rtl/sat_counter.sv | 16 +
 rtl/pipeline_ctrl.sv | 112 +++++++++++
 tb/tb_pipeline_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_MEM_WAIT, ST_HALT} pctrl_state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                  cnt <= '0;
    else if (clr)                  cnt <= '0;
    else if (inc && (cnt != '1))   cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: cache-miss freeze, load-use
// bubble, taken-branch flush, saturating perf counters and memory timeout halt.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_noop_o,
  output logic             pipe_stall_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  localparam int WW = $clog2(TIMEOUT);
  // The stalled RUN cycle that enters MEM_WAIT is the first of TIMEOUT, so the
  // halting edge is taken when the counter shows TIMEOUT-2.
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 2);

  pctrl_state_t  state;
  logic [WW-1:0] wait_cnt;
  logic          active, mem_stall, lu;

  assign active    = (state == ST_RUN) || (state == ST_MEM_WAIT);
  assign mem_stall = active && mem_req_i && !mem_ack_i;
  assign lu        = ex_memread_i && (ex_rd_i != REG_ZERO) &&
                     ((id_use_rs1_i && (ex_rd_i == id_rs1_i)) ||
                      (id_use_rs2_i && (ex_rd_i == id_rs2_i)));

  always_comb begin
    pc_write_o    = 1'b1;
    if_id_write_o = 1'b1;
    if_id_flush_o = 1'b0;
    id_ex_noop_o  = 1'b0;
    pipe_stall_o  = 1'b0;
    if (!active) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      id_ex_noop_o  = 1'b1;
      pipe_stall_o  = 1'b1;
    end else if (mem_stall) begin
      // Freeze, not bubble: the EX instruction must survive the miss.
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      pipe_stall_o  = 1'b1;
    end else if (lu) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      id_ex_noop_o  = 1'b1;
    end else if (branch_taken_i) begin
      if_id_flush_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      err_o    <= 1'b0;
    end else if ((state != ST_HALT) && !start_i) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state <= ST_RUN;
        ST_RUN: begin
          if (mem_req_i && !mem_ack_i) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ack_i) begin
            state <= ST_RUN;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= ST_HALT;
            err_o <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IDLE;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .inc(active && pipe_stall_o), .clr(1'b0), .cnt(stall_cnt_o)
  );
  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .inc(active && id_ex_noop_o), .clr(1'b0), .cnt(bubble_cnt_o)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .inc(active && if_id_flush_o), .clr(1'b0), .cnt(flush_cnt_o)
  );
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: vector table, corner sequences and random traffic
// against a cycle-level reference model; a second 2-bit-counter instance checks saturation.
module tb_pipeline_ctrl;
  localparam int TO = 8;
  localparam int M_IDLE = 0, M_RUN = 1, M_WAIT = 2, M_HALT = 3;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic use1 = 1'b0, use2 = 1'b0, memread = 1'b0, br = 1'b0, req = 1'b0, ack = 1'b0;

  logic pc_w, ifid_w, flush, noop, stall, err;
  logic [15:0] scnt, bcnt, fcnt;
  logic b_pc_w, b_ifid_w, b_flush, b_noop, b_stall, b_err;
  logic [1:0] b_scnt, b_bcnt, b_fcnt;

  int tests = 0, fails = 0;

  // reference model: mode, stalled cycles so far in the current miss, raw event counts
  int m_st = M_IDLE, m_pend = 0, n_st = 0, n_bu = 0, n_fl = 0;
  bit m_err = 1'b0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.CNT_W(16), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_use_rs1_i(use1), .id_use_rs2_i(use2),
    .ex_memread_i(memread), .ex_rd_i(rd), .branch_taken_i(br),
    .mem_req_i(req), .mem_ack_i(ack),
    .pc_write_o(pc_w), .if_id_write_o(ifid_w), .if_id_flush_o(flush),
    .id_ex_noop_o(noop), .pipe_stall_o(stall), .err_o(err),
    .stall_cnt_o(scnt), .bubble_cnt_o(bcnt), .flush_cnt_o(fcnt)
  );

  pipeline_ctrl #(.CNT_W(2), .TIMEOUT(TO)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_use_rs1_i(use1), .id_use_rs2_i(use2),
    .ex_memread_i(memread), .ex_rd_i(rd), .branch_taken_i(br),
    .mem_req_i(req), .mem_ack_i(ack),
    .pc_write_o(b_pc_w), .if_id_write_o(b_ifid_w), .if_id_flush_o(b_flush),
    .id_ex_noop_o(b_noop), .pipe_stall_o(b_stall), .err_o(b_err),
    .stall_cnt_o(b_scnt), .bubble_cnt_o(b_bcnt), .flush_cnt_o(b_fcnt)
  );

  typedef struct {
    logic start; logic [4:0] rs1, rs2, rd;
    logic use1, use2, memread, br, req, ack;
    logic [4:0] exp;  // {pc_write, if_id_write, if_id_flush, id_ex_noop, pipe_stall}
  } vec_t;
  vec_t tbl[11];

  function automatic vec_t mk(input logic s, input logic [4:0] r1, input logic [4:0] r2,
                              input logic [4:0] d, input logic u1, input logic u2,
                              input logic mr, input logic b, input logic rq, input logic ak,
                              input logic [4:0] e);
    vec_t v;
    v.start = s; v.rs1 = r1; v.rs2 = r2; v.rd = d; v.use1 = u1; v.use2 = u2;
    v.memread = mr; v.br = b; v.req = rq; v.ack = ak; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat16(input int c);
    return (c > 65535) ? 16'hffff : 16'(c);
  endfunction
  function automatic logic [1:0] sat2(input int c);
    return (c > 3) ? 2'd3 : 2'(c);
  endfunction

  function automatic logic [4:0] m_ctrl();
    bit lu;
    lu = memread && (rd != 5'd0) && ((use1 && rd == rs1) || (use2 && rd == rs2));
    if (m_st == M_IDLE || m_st == M_HALT) return 5'b00011;
    if (req && !ack)                      return 5'b00001;
    if (lu)                               return 5'b00010;
    if (br)                               return 5'b11100;
    return 5'b11000;
  endfunction

  task automatic model_edge();
    logic [4:0] e;
    e = m_ctrl();
    if (m_st == M_RUN || m_st == M_WAIT) begin
      if (e[0]) n_st++;
      if (e[1]) n_bu++;
      if (e[2]) n_fl++;
    end
    if (m_st == M_HALT) m_st = M_HALT;
    else if (!start) m_st = M_IDLE;
    else if (m_st == M_IDLE) m_st = M_RUN;
    else if (m_st == M_RUN) begin
      if (req && !ack) begin m_st = M_WAIT; m_pend = 1; end
    end else begin
      if (ack) m_st = M_RUN;
      else if (m_pend + 1 == TO) begin m_st = M_HALT; m_err = 1'b1; end
      else m_pend++;
    end
  endtask

  task automatic check_all(input string tag);
    logic [4:0] e;
    e = m_ctrl();
    chk({tag, " ctrl"}, 64'({pc_w, ifid_w, flush, noop, stall}), 64'(e));
    chk({tag, " err"}, 64'(err), 64'(m_err));
    chk({tag, " cnt16"}, 64'({scnt, bcnt, fcnt}), 64'({sat16(n_st), sat16(n_bu), sat16(n_fl)}));
    chk({tag, " inst2"}, 64'({b_pc_w, b_ifid_w, b_flush, b_noop, b_stall, b_err, b_scnt, b_bcnt, b_fcnt}),
        64'({e, m_err, sat2(n_st), sat2(n_bu), sat2(n_fl)}));
  endtask

  // inputs are set just after a negedge; outputs checked mid-low-phase
  task automatic step(input string tag);
    #1 check_all(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // asynchronous reset asserted mid-cycle; outputs must go idle at once
  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, " rst ctrl"}, 64'({pc_w, ifid_w, flush, noop, stall}), 64'(5'b00011));
    chk({tag, " rst err"}, 64'({err, b_err}), 64'(2'b00));
    chk({tag, " rst cnt"}, 64'({scnt, bcnt, fcnt}), 64'(0));
    m_st = M_IDLE; m_pend = 0; m_err = 1'b0; n_st = 0; n_bu = 0; n_fl = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle_inputs();
    rs1 = '0; rs2 = '0; rd = '0; use1 = 1'b0; use2 = 1'b0;
    memread = 1'b0; br = 1'b0; req = 1'b0; ack = 1'b0;
  endtask

  initial begin
    tbl[0]  = mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00011);
    tbl[1]  = mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11000);
    tbl[2]  = mk(1'b1, 5'd0, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00010);
    tbl[3]  = mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11000);
    tbl[4]  = mk(1'b1, 5'd7, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11000);
    tbl[5]  = mk(1'b1, 5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00010);
    tbl[6]  = mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b11100);
    tbl[7]  = mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b11000);
    tbl[8]  = mk(1'b1, 5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'b00001);
    tbl[9]  = mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'b11100);
    tbl[10] = mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11000);

    @(negedge clk);
    do_reset("init");

    // vector table from a fresh reset
    foreach (tbl[i]) begin
      start = tbl[i].start; rs1 = tbl[i].rs1; rs2 = tbl[i].rs2; rd = tbl[i].rd;
      use1 = tbl[i].use1; use2 = tbl[i].use2; memread = tbl[i].memread;
      br = tbl[i].br; req = tbl[i].req; ack = tbl[i].ack;
      #1 chk($sformatf("vec%0d", i), 64'({pc_w, ifid_w, flush, noop, stall}), 64'(tbl[i].exp));
      step($sformatf("vec%0d", i));
    end
    #1 chk("table counts", 64'({scnt, bcnt, fcnt}), 64'({16'd1, 16'd2, 16'd2}));

    // 4-cycle miss then ack
    do_reset("miss");
    idle_inputs(); start = 1'b1;
    step("miss idle"); step("miss run");
    req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 chk("miss freeze", 64'({stall, noop}), 64'(2'b10));
      step("miss wait");
    end
    ack = 1'b1;
    #1 chk("miss ack stall", 64'(stall), 64'(1'b0));
    step("miss ack");
    idle_inputs();
    #1 chk("miss stall_cnt", 64'(scnt), 64'(16'd4));
    chk("miss back to run", 64'({pc_w, ifid_w, stall}), 64'(3'b110));
    step("miss after");

    // timeout -> HALT, then reset clears err
    do_reset("to");
    idle_inputs(); start = 1'b1;
    step("to idle"); step("to run");
    req = 1'b1;
    for (int k = 1; k <= TO; k++) begin
      if (k == TO) #1 chk("to err early", 64'(err), 64'(1'b0));
      step("to wait");
    end
    #1 chk("to err set", 64'({err, b_err}), 64'(2'b11));
    chk("to halt ctrl", 64'({pc_w, ifid_w, flush, noop, stall}), 64'(5'b00011));
    chk("to stall_cnt", 64'(scnt), 64'(16'd8));
    ack = 1'b1;
    step("halt hold1");
    start = 1'b0;
    step("halt hold2");
    start = 1'b1;
    do_reset("halt");

    // reset in the middle of a miss
    idle_inputs(); start = 1'b1;
    step("mid idle"); step("mid run");
    req = 1'b1;
    step("mid w1"); step("mid w2"); step("mid w3");
    do_reset("mid");
    step("mid restart");

    // 2-bit counter saturation on five flushes
    do_reset("sat");
    idle_inputs(); start = 1'b1;
    step("sat idle");
    br = 1'b1;
    for (int k = 0; k < 5; k++) step("sat br");
    br = 1'b0;
    #1 chk("sat flush2", 64'(b_fcnt), 64'(2'd3));
    chk("sat flush16", 64'(fcnt), 64'(16'd5));
    step("sat end");

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      start   = ($urandom_range(0, 40) != 0);
      rs1     = 5'($urandom_range(0, 3));
      rs2     = 5'($urandom_range(0, 3));
      rd      = 5'($urandom_range(0, 3));
      use1    = 1'($urandom_range(0, 1));
      use2    = 1'($urandom_range(0, 1));
      memread = 1'($urandom_range(0, 1));
      br      = ($urandom_range(0, 3) == 0);
      req     = ($urandom_range(0, 2) == 0) || (m_st == M_WAIT && $urandom_range(0, 3) != 0);
      ack     = ($urandom_range(0, 2) == 0);
      step("rand");
      if (m_st == M_HALT) begin
        step("rand halt");
        do_reset("rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
